// File: rtl/hazard_bubble_ctrl.sv
// ID/EX control register with load-use stall and branch-flush bubble insertion.
// Bubbles zero the control bundle; a saturating counter records how many were inserted.
module hazard_bubble_ctrl #(
   parameter int unsigned CTRL_W       = 19,
   parameter int unsigned REG_AW       = 5,
   parameter int unsigned STALL_CYCLES = 1,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              flush_in,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic              valid_out,
   output logic              stall_pc,
   output logic              stall_ifid,
   output logic              flush_ifid,
   output logic [15:0]       bubble_cnt
);

   typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

   localparam logic [3:0] StallRem = 4'(STALL_CYCLES - 1);
   localparam logic [3:0] FlushRem = 4'(FLUSH_CYCLES - 1);

   state_e              state_q, state_d;
   logic [3:0]          rem_q, rem_d;
   logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
   logic                valid_q, valid_d;
   logic [15:0]         cnt_q;
   logic                bubble;
   logic                stall;
   logic                flush;
   logic                hazard;

   assign hazard = ex_memread && (ex_rd != '0) && id_valid &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      ctrl_d  = ctrl_in;
      valid_d = id_valid;
      bubble  = 1'b0;
      stall   = 1'b0;
      flush   = 1'b0;
      if (flush_in) begin
         // Flush wins over a hazard and aborts any stall in progress.
         flush   = 1'b1;
         ctrl_d  = '0;
         valid_d = 1'b0;
         bubble  = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            state_d = StFlush;
            rem_d   = FlushRem;
         end else begin
            state_d = StRun;
            rem_d   = '0;
         end
      end else begin
         unique case (state_q)
            StRun: begin
               if (hazard) begin
                  stall   = 1'b1;
                  ctrl_d  = '0;
                  valid_d = 1'b0;
                  bubble  = 1'b1;
                  if (STALL_CYCLES > 1) begin
                     state_d = StStall;
                     rem_d   = StallRem;
                  end
               end else begin
                  bubble = !id_valid;
               end
            end
            StStall, StFlush: begin
               stall   = (state_q == StStall);
               flush   = (state_q == StFlush);
               ctrl_d  = '0;
               valid_d = 1'b0;
               bubble  = 1'b1;
               if (rem_q <= 4'd1) begin
                  state_d = StRun;
                  rem_d   = '0;
               end else begin
                  rem_d = rem_q - 4'd1;
               end
            end
            default: begin
               state_d = StRun;
               rem_d   = '0;
            end
         endcase
      end
      if (rst) begin
         stall = 1'b0;
         flush = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         rem_q   <= '0;
         ctrl_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         ctrl_q  <= ctrl_d;
         valid_q <= valid_d;
         if (bubble && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
         end
      end
   end

   assign ctrl_out   = ctrl_q;
   assign valid_out  = valid_q;
   assign stall_pc   = stall;
   assign stall_ifid = stall;
   assign flush_ifid = flush;
   assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_bubble_ctrl.sv
// Directed plus random stimulus for hazard_bubble_ctrl against a bubble-budget reference model.
module tb_hazard_bubble_ctrl;

   localparam int CW = 19;
   localparam int AW = 5;
   localparam int SC = 3;
   localparam int FC = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] ctrl_in;
   logic          id_valid;
   logic [AW-1:0] id_rs1, id_rs2, ex_rd;
   logic          id_use_rs1, id_use_rs2, ex_memread, flush_in;
   logic [CW-1:0] ctrl_out;
   logic          valid_out, stall_pc, stall_ifid, flush_ifid;
   logic [15:0]   bubble_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: outstanding bubble budgets and expected registered values.
   int            stall_left = 0;
   int            flush_left = 0;
   logic [CW-1:0] m_ctrl = '0;
   logic          m_valid = 1'b0;
   int            m_cnt = 0;

   hazard_bubble_ctrl #(
      .CTRL_W(CW), .REG_AW(AW), .STALL_CYCLES(SC), .FLUSH_CYCLES(FC)
   ) dut (
      .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_memread(ex_memread), .ex_rd(ex_rd), .flush_in(flush_in),
      .ctrl_out(ctrl_out), .valid_out(valid_out), .stall_pc(stall_pc),
      .stall_ifid(stall_ifid), .flush_ifid(flush_ifid), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_in(input logic r, input logic [CW-1:0] c, input logic v,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic u1, input logic u2, input logic mr,
                         input logic [AW-1:0] rd, input logic fl);
      rst = r; ctrl_in = c; id_valid = v; id_rs1 = r1; id_rs2 = r2;
      id_use_rs1 = u1; id_use_rs2 = u2; ex_memread = mr; ex_rd = rd; flush_in = fl;
   endtask

   // One clock: check combinational outputs, advance model, check registered outputs.
   task automatic step();
      logic hz, e_stall, e_flush, bub;
      hz = ex_memread && (ex_rd != 0) && id_valid &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      e_stall = 1'b0; e_flush = 1'b0; bub = 1'b1;
      #1;
      if (rst) begin
         stall_left = 0; flush_left = 0;
      end else if (flush_in) begin
         e_flush = 1'b1; flush_left = FC - 1; stall_left = 0;
      end else if (flush_left > 0) begin
         e_flush = 1'b1; flush_left--;
      end else if (stall_left > 0) begin
         e_stall = 1'b1; stall_left--;
      end else if (hz) begin
         e_stall = 1'b1; stall_left = SC - 1;
      end else begin
         bub = !id_valid;
      end
      chk("stall_pc", 32'(stall_pc), 32'(e_stall));
      chk("stall_ifid", 32'(stall_ifid), 32'(e_stall));
      chk("flush_ifid", 32'(flush_ifid), 32'(e_flush));
      if (rst) begin
         m_ctrl = '0; m_valid = 1'b0; m_cnt = 0;
      end else if (e_stall || e_flush) begin
         m_ctrl = '0; m_valid = 1'b0;
      end else begin
         m_ctrl = ctrl_in; m_valid = id_valid;
      end
      if (!rst && bub && m_cnt < 65535) m_cnt++;
      @(posedge clk);
      #1;
      chk("ctrl_out", 32'(ctrl_out), 32'(m_ctrl));
      chk("valid_out", 32'(valid_out), 32'(m_valid));
      chk("bubble_cnt", 32'(bubble_cnt), 32'(m_cnt));
   endtask

   initial begin
      int base;
      set_in(1, '0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      step(); step();
      chk("reset_cnt", 32'(bubble_cnt), 32'd0);

      // Plain pass-through, one-cycle latency.
      set_in(0, 19'h12345, 1, 1, 2, 1, 1, 0, 0, 0);
      base = m_cnt;
      step();
      chk("pass_ctrl", 32'(ctrl_out), 32'h12345);
      chk("pass_cnt_same", 32'(bubble_cnt), 32'(base));

      // Load-use on rs2: three stall cycles and three bubbles.
      base = m_cnt;
      set_in(0, 19'h0ABCD, 1, 1, 5, 0, 1, 1, 5, 0);
      for (int i = 0; i < SC; i++) begin
         #1 chk("lu_stall_pc", 32'(stall_pc), 32'd1);
         step();
      end
      set_in(0, 19'h0ABCD, 1, 1, 5, 0, 1, 0, 0, 0);
      step();
      chk("lu_cnt_plus3", 32'(bubble_cnt), 32'(base + 3));
      chk("lu_release", 32'(ctrl_out), 32'h0ABCD);

      // ex_rd = 0 never stalls.
      set_in(0, 19'h55555, 1, 0, 0, 1, 1, 1, 0, 0);
      step();
      chk("rd0_ctrl", 32'(ctrl_out), 32'h55555);

      // Flush in second stall cycle.
      set_in(0, 19'h11111, 1, 7, 0, 1, 0, 1, 7, 0);
      step();
      set_in(0, 19'h11111, 1, 7, 0, 1, 0, 1, 7, 1);
      #1 chk("fl_stall_drop", 32'(stall_pc), 32'd0);
      step();
      set_in(0, 19'h22222, 1, 7, 0, 1, 0, 1, 7, 0);
      #1 chk("fl_second", 32'(flush_ifid), 32'd1);
      step();
      set_in(0, 19'h22222, 1, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("fl_run", 32'(ctrl_out), 32'h22222);

      // Reset during FLUSH.
      set_in(0, 19'h33333, 1, 0, 0, 0, 0, 0, 0, 1);
      step();
      set_in(1, 19'h33333, 1, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("rst_flush_valid", 32'(valid_out), 32'd0);
      set_in(0, 19'h44444, 1, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("rst_flush_pass", 32'(ctrl_out), 32'h44444);

      // Random traffic with small register indices to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         set_in(($urandom_range(0, 60) == 0), CW'($urandom), ($urandom_range(0, 5) != 0),
                AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0),
                AW'($urandom_range(0, 3)), ($urandom_range(0, 12) == 0));
         step();
      end

      // Saturation: drive to 0xFFFE, then two more bubbles and hold.
      set_in(1, '0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      set_in(0, '0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (65534) @(posedge clk);
      #1;
      m_cnt = 65534;
      chk("sat_fffe", 32'(bubble_cnt), 32'hFFFE);
      step(); step(); step();
      chk("sat_hold", 32'(bubble_cnt), 32'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
